// File: rtl/pwm_dac_gen.sv
// Sigma-delta dithered PWM: 8-bit duty per 256-clock period, 16-period frame adds S[k] extra high clock.
// One-cycle registered output; cfg_i is sampled only at frame boundaries, and sync_i forces a restart.
module pwm_dac_gen #(
  parameter int CCW  = 24,
  parameter int FULL = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [CCW-1:0] cfg_i,
  input  logic           sync_i,
  output logic           pwm_o,
  output logic           frame_o,
  output logic [3:0]     bcnt_o
);

  localparam logic [7:0] FULL_C = 8'(FULL);

  logic [7:0]  vcnt_q, vcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  v_q, v_d;
  logic [15:0] s_q, s_d;
  logic [8:0]  thr_q, thr_d;
  logic        pwm_q, pwm_d;
  logic        frame_q, frame_d;
  logic [3:0]  bnext;

  always_comb begin
    vcnt_d  = vcnt_q;
    bcnt_d  = bcnt_q;
    v_d     = v_q;
    s_d     = s_q;
    thr_d   = thr_q;
    frame_d = 1'b0;
    bnext   = bcnt_q + 4'd1;
    pwm_d   = ({1'b0, vcnt_q} < thr_q);

    if (sync_i) begin
      // Park just before a frame boundary; the next non-sync edge latches cfg_i.
      vcnt_d = FULL_C;
      bcnt_d = 4'hF;
    end else begin
      vcnt_d = (vcnt_q == FULL_C) ? 8'd0 : vcnt_q + 8'd1;
      if (vcnt_q == FULL_C) begin
        bcnt_d = bnext;
        if (bcnt_q == 4'hF) begin
          v_d     = cfg_i[CCW-1 -: 8];
          s_d     = cfg_i[15:0];
          thr_d   = {1'b0, cfg_i[CCW-1 -: 8]} + {8'd0, cfg_i[0]};
          frame_d = 1'b1;
        end else begin
          thr_d = {1'b0, v_q} + {8'd0, s_q[bnext]};
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vcnt_q  <= FULL_C;
      bcnt_q  <= 4'hF;
      v_q     <= 8'd0;
      s_q     <= 16'd0;
      thr_q   <= 9'd0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      vcnt_q  <= vcnt_d;
      bcnt_q  <= bcnt_d;
      v_q     <= v_d;
      s_q     <= s_d;
      thr_q   <= thr_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign frame_o = frame_q;
  assign bcnt_o  = bcnt_q;

endmodule

// File: tb/tb_pwm_dac_gen.sv
// Directed bench for pwm_dac_gen: per-period high-clock tables plus sync/reset/cfg-change sequences.
module tb_pwm_dac_gen;

  logic        clk;
  logic        rst_a, rst_b;
  logic [23:0] cfg;
  logic        sync;
  logic        pwm_a, frame_a, pwm_b, frame_b;
  logic [3:0]  bcnt_a, bcnt_b;

  int tests = 0;
  int fails = 0;
  int hi[16];
  int tot;
  int frame_bad;

  pwm_dac_gen #(.CCW(24), .FULL(255)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .cfg_i(cfg), .sync_i(sync),
    .pwm_o(pwm_a), .frame_o(frame_a), .bcnt_o(bcnt_a)
  );

  pwm_dac_gen #(.CCW(24), .FULL(255)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .cfg_i(cfg), .sync_i(sync),
    .pwm_o(pwm_b), .frame_o(frame_b), .bcnt_o(bcnt_b)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  typedef struct {
    logic [23:0] cfg;
    int          base;
    logic [15:0] mask;
    int          total;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_a = 1'b1;
    tick();
    chk("reset_pwm", {31'd0, pwm_a}, 0);
    chk("reset_frame", {31'd0, frame_a}, 0);
    chk("reset_bcnt", {28'd0, bcnt_a}, 15);
    rst_a = 1'b0;
  endtask

  // Starts right after a latch edge of dut_a; ends on the next latch edge.
  task automatic collect(input int chg_at, input logic [23:0] chg_cfg);
    for (int k = 0; k < 16; k++) hi[k] = 0;
    tot = 0;
    frame_bad = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (pwm_a === 1'b1) begin
        hi[i / 256]++;
        tot++;
      end
      if (frame_a !== ((i == 4095) ? 1'b1 : 1'b0)) frame_bad++;
      if (i == chg_at) cfg = chg_cfg;
    end
  endtask

  initial begin
    int mism;
    rst_a = 1'b1;
    rst_b = 1'b1;
    sync  = 1'b0;
    cfg   = 24'h0;

    vecs[0] = '{cfg: 24'h80_0000, base: 128, mask: 16'h0000, total: 2048};
    vecs[1] = '{cfg: 24'h00_0000, base: 0,   mask: 16'h0000, total: 0};
    vecs[2] = '{cfg: 24'hFF_FFFF, base: 255, mask: 16'hFFFF, total: 4096};
    vecs[3] = '{cfg: 24'h40_5555, base: 64,  mask: 16'h5555, total: 1032};
    vecs[4] = '{cfg: 24'h10_0001, base: 16,  mask: 16'h0001, total: 257};
    vecs[5] = '{cfg: 24'h01_8000, base: 1,   mask: 16'h8000, total: 17};
    vecs[6] = '{cfg: 24'h00_0001, base: 0,   mask: 16'h0001, total: 1};

    tick();
    tick();

    for (int r = 0; r < 7; r++) begin
      cfg = vecs[r].cfg;
      do_reset();
      tick();
      chk($sformatf("v%0d_latch_frame", r), {31'd0, frame_a}, 1);
      chk($sformatf("v%0d_latch_pwm", r), {31'd0, pwm_a}, 0);
      chk($sformatf("v%0d_latch_bcnt", r), {28'd0, bcnt_a}, 0);
      collect(-1, 24'h0);
      for (int k = 0; k < 16; k++)
        chk($sformatf("v%0d_period%0d_hi", r, k), hi[k], vecs[r].base + int'(vecs[r].mask[k]));
      chk($sformatf("v%0d_total", r), tot, vecs[r].total);
      chk($sformatf("v%0d_frame_pulse", r), frame_bad, 0);
    end

    // First rise two edges after reset release.
    cfg = 24'h80_0000;
    do_reset();
    tick();
    chk("rise_edge1_pwm", {31'd0, pwm_a}, 0);
    tick();
    chk("rise_edge2_pwm", {31'd0, pwm_a}, 1);

    // Mid-frame cfg change only takes effect at the next frame.
    cfg = 24'h10_0001;
    do_reset();
    tick();
    collect(1000, 24'h20_0000);
    chk("chg_cur_p0", hi[0], 17);
    chk("chg_cur_p1", hi[1], 16);
    chk("chg_cur_p15", hi[15], 16);
    chk("chg_cur_total", tot, 257);
    collect(-1, 24'h0);
    chk("chg_next_p0", hi[0], 32);
    chk("chg_next_p9", hi[9], 32);
    chk("chg_next_total", tot, 512);

    // Sync coinciding with the natural frame boundary defers the latch one edge.
    cfg = 24'h40_5555;
    do_reset();
    tick();
    for (int i = 0; i < 4095; i++) tick();
    sync = 1'b1;
    tick();
    chk("sync_nat_frame", {31'd0, frame_a}, 0);
    chk("sync_nat_bcnt", {28'd0, bcnt_a}, 15);
    sync = 1'b0;
    tick();
    chk("sync_nat_latch", {31'd0, frame_a}, 1);
    chk("sync_nat_latch_bcnt", {28'd0, bcnt_a}, 0);

    // Two instances with different phases, aligned by one sync pulse.
    rst_b = 1'b1;
    do_reset();
    for (int i = 0; i < 37; i++) tick();
    rst_b = 1'b0;
    for (int i = 0; i < 1234; i++) tick();
    sync = 1'b1;
    tick();
    chk("sync_a_frame0", {31'd0, frame_a}, 0);
    chk("sync_b_frame0", {31'd0, frame_b}, 0);
    sync = 1'b0;
    tick();
    chk("sync_a_frame", {31'd0, frame_a}, 1);
    chk("sync_b_frame", {31'd0, frame_b}, 1);
    chk("sync_a_bcnt", {28'd0, bcnt_a}, 0);
    chk("sync_b_bcnt", {28'd0, bcnt_b}, 0);
    mism = 0;
    tot = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (pwm_a !== pwm_b) mism++;
      if (pwm_b === 1'b1) tot++;
    end
    chk("sync_ab_diff", mism, 0);
    chk("sync_b_total", tot, 1032);

    // Reset mid-period while high.
    cfg = 24'h80_0000;
    do_reset();
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_pre_pwm", {31'd0, pwm_a}, 1);
    rst_a = 1'b1;
    tick();
    chk("midrst_pwm", {31'd0, pwm_a}, 0);
    chk("midrst_bcnt", {28'd0, bcnt_a}, 15);
    rst_a = 1'b0;
    tick();
    chk("midrst_latch_frame", {31'd0, frame_a}, 1);
    chk("midrst_latch_pwm", {31'd0, pwm_a}, 0);
    tick();
    chk("midrst_rise_pwm", {31'd0, pwm_a}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
